// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the memory.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_ack;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_ack, if_rdata, ls_ack, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_ack, if_rdata, ls_ack, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store; one transaction at a time, IDLE -> ACCESS -> DONE.
module mem_port_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              lastLs_q;
  logic              grantLs_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ifRdata_q;
  logic [DATA_W-1:0] lsRdata_q;
  logic              memEn_q;
  logic              memWe_q;
  logic              busy_q;
  logic              ifAck_q;
  logic              lsAck_q;

  logic              anyReq_d;
  logic              grantLs_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // LS wins when it is the only requester, or on a tie when IF was served last.
  always_comb begin
    anyReq_d  = bus.if_req | bus.ls_req;
    grantLs_d = bus.ls_req & (~bus.if_req | ~lastLs_q);
    addr_d    = grantLs_d ? bus.ls_addr : bus.if_addr;
    we_d      = grantLs_d & bus.ls_we;
    wdata_d   = grantLs_d ? bus.ls_wdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lastLs_q  <= 1'b1;
      grantLs_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ifRdata_q <= '0;
      lsRdata_q <= '0;
      memEn_q   <= 1'b0;
      memWe_q   <= 1'b0;
      busy_q    <= 1'b0;
      ifAck_q   <= 1'b0;
      lsAck_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq_d) begin
            state_q   <= ACCESS;
            cnt_q     <= CNT_LOAD;
            lastLs_q  <= grantLs_d;
            grantLs_q <= grantLs_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            memEn_q   <= 1'b1;
            memWe_q   <= we_d;
            busy_q    <= 1'b1;
          end
        end

        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            memEn_q <= 1'b0;
            memWe_q <= 1'b0;
            ifAck_q <= ~grantLs_q;
            lsAck_q <= grantLs_q;
            // Only reads refresh the granted port's rdata; stores leave it alone.
            if (!we_q) begin
              if (grantLs_q) begin
                lsRdata_q <= bus.mem_rdata;
              end else begin
                ifRdata_q <= bus.mem_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          ifAck_q <= 1'b0;
          lsAck_q <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          memEn_q <= 1'b0;
          memWe_q <= 1'b0;
          ifAck_q <= 1'b0;
          lsAck_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en    = memEn_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = ifAck_q;
  assign bus.ls_ack    = lsAck_q;
  assign bus.if_rdata  = ifRdata_q;
  assign bus.ls_rdata  = lsRdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic compared against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  int assertCount;
  int failCount;

  // Transaction-level model state
  bit          lastGrantLs;
  logic [15:0] expIfRdata;
  logic [15:0] expLsRdata;

  // Observations gathered by runTxn for one transaction on the WAIT_CYCLES=2 instance
  int          obsAck;
  int          obsEn;
  bit          obsAckIf, obsAckLs, obsOverlap, obsBusyLow, obsWeOutside, obsUnstable;
  bit          obsBusyAfter, obsAckAfter, obsEnAfter;
  logic [7:0]  obsAddr;
  logic        obsWe;
  logic [15:0] obsWdata;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus2 ();
  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus15 ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );
  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .bus(bus15)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Round-robin rule: a lone requester always wins, a tie goes to whoever was not served last.
  task automatic modelGrant(input bit ifReq, input bit lsReq, output bit isLs);
    if (ifReq && lsReq) isLs = !lastGrantLs;
    else                isLs = lsReq;
    lastGrantLs = isLs;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus2.if_req = 1'b0;
    bus2.ls_req = 1'b0;
    lastGrantLs = 1'b1;
    expIfRdata  = '0;
    expLsRdata  = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one request pattern at a negedge and watches until ack; returns at the following negedge.
  task automatic runTxn(input bit ifReq, input logic [7:0] ifAddr, input bit lsReq,
                        input bit lsWe, input logic [7:0] lsAddr, input logic [15:0] lsWdata,
                        input logic [15:0] memVal, input bit hold, input bit perturb);
    bit seenEn;
    seenEn = 1'b0;
    bus2.if_req    = ifReq;
    bus2.if_addr   = ifAddr;
    bus2.ls_req    = lsReq;
    bus2.ls_we     = lsWe;
    bus2.ls_addr   = lsAddr;
    bus2.ls_wdata  = lsWdata;
    bus2.mem_rdata = memVal;
    obsAck = 0; obsEn = 0;
    obsAckIf = 0; obsAckLs = 0; obsOverlap = 0; obsBusyLow = 0; obsWeOutside = 0; obsUnstable = 0;
    obsAddr = '0; obsWe = 1'b0; obsWdata = '0;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus2.if_req = 1'b0;
      bus2.ls_req = 1'b0;
    end
    for (int k = 1; k <= 40 && obsAck == 0; k++) begin
      @(negedge clk);
      if (bus2.mem_en) begin
        if (!seenEn) begin
          obsAddr = bus2.mem_addr; obsWe = bus2.mem_we; obsWdata = bus2.mem_wdata;
          seenEn = 1'b1;
        end else if (bus2.mem_addr !== obsAddr || bus2.mem_we !== obsWe || bus2.mem_wdata !== obsWdata) begin
          obsUnstable = 1'b1;
        end
        obsEn++;
      end else if (bus2.mem_we) begin
        obsWeOutside = 1'b1;
      end
      if (!bus2.busy) obsBusyLow = 1'b1;
      if (bus2.if_ack && bus2.ls_ack) obsOverlap = 1'b1;
      if (bus2.if_ack || bus2.ls_ack) begin
        obsAck = k; obsAckIf = bus2.if_ack; obsAckLs = bus2.ls_ack;
      end
      if (perturb) begin
        bus2.ls_addr  = 8'($urandom);
        bus2.if_addr  = 8'($urandom);
        bus2.ls_wdata = 16'($urandom);
        bus2.ls_we    = 1'($urandom);
      end
    end
    @(negedge clk);
    obsBusyAfter = bus2.busy;
    obsAckAfter  = bus2.if_ack | bus2.ls_ack;
    obsEnAfter   = bus2.mem_en | bus2.mem_we;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus2.if_req = 1'b1;
    @(negedge clk);
    assertCount++;
    if ({bus2.busy, bus2.if_ack, bus2.ls_ack, bus2.mem_en, bus2.mem_we} !== 5'b0) begin
      failCount++;
      $display("FAIL reset_ctrl: busy/ifAck/lsAck/memEn/memWe = %b, expected 00000",
               {bus2.busy, bus2.if_ack, bus2.ls_ack, bus2.mem_en, bus2.mem_we});
    end
    assertCount++;
    if ({bus2.mem_addr, bus2.mem_wdata, bus2.if_rdata, bus2.ls_rdata} !== 56'd0) begin
      failCount++;
      $display("FAIL reset_data: addr=%h wdata=%h ifRdata=%h lsRdata=%h, expected all 0",
               bus2.mem_addr, bus2.mem_wdata, bus2.if_rdata, bus2.ls_rdata);
    end
    assertCount++;
    if ({bus1.busy, bus15.busy} !== 2'b0) begin
      failCount++;
      $display("FAIL reset_busy_others: busy1=%b busy15=%b, expected 0", bus1.busy, bus15.busy);
    end
    bus2.if_req = 1'b0;
    rst = 1'b0;
    lastGrantLs = 1'b1;
    expIfRdata  = '0;
    expLsRdata  = '0;
  endtask

  task automatic test_if_read();
    runTxn(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000, 16'hABCD, 1'b0, 1'b0);
    expIfRdata = 16'hABCD;
    lastGrantLs = 1'b0;
    assertCount++;
    if (obsEn !== 2 || obsAddr !== 8'h10 || obsWe !== 1'b0) begin
      failCount++;
      $display("FAIL if_read_mem: enCycles=%0d addr=%h we=%b, expected 2/10/0", obsEn, obsAddr, obsWe);
    end
    assertCount++;
    if (obsAck !== 3 || obsAckIf !== 1'b1 || obsAckLs !== 1'b0) begin
      failCount++;
      $display("FAIL if_read_ack: ackCycle=%0d ifAck=%b lsAck=%b, expected 3/1/0", obsAck, obsAckIf, obsAckLs);
    end
    assertCount++;
    if (bus2.if_rdata !== expIfRdata || obsAckAfter !== 1'b0 || obsBusyAfter !== 1'b0) begin
      failCount++;
      $display("FAIL if_read_data: ifRdata=%h ackAfter=%b busyAfter=%b, expected %h/0/0",
               bus2.if_rdata, obsAckAfter, obsBusyAfter, expIfRdata);
    end
  endtask

  task automatic test_store();
    bit isLs;
    modelGrant(1'b0, 1'b1, isLs);
    runTxn(1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 16'h0000, 16'h5A5A, 1'b0, 1'b0);
    expLsRdata = 16'h5A5A;
    assertCount++;
    if (bus2.ls_rdata !== expLsRdata || bus2.if_rdata !== expIfRdata) begin
      failCount++;
      $display("FAIL ls_load_data: lsRdata=%h ifRdata=%h, expected %h/%h",
               bus2.ls_rdata, bus2.if_rdata, expLsRdata, expIfRdata);
    end
    modelGrant(1'b0, 1'b1, isLs);
    runTxn(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 16'h1234, 16'hFFFF, 1'b0, 1'b0);
    assertCount++;
    if (obsEn !== 2 || obsWe !== 1'b1 || obsAddr !== 8'h20 || obsWdata !== 16'h1234 || obsUnstable) begin
      failCount++;
      $display("FAIL store_mem: en=%0d we=%b addr=%h wdata=%h unstable=%b, expected 2/1/20/1234/0",
               obsEn, obsWe, obsAddr, obsWdata, obsUnstable);
    end
    assertCount++;
    if (obsAck !== 3 || obsAckLs !== 1'b1 || obsAckIf !== 1'b0 || obsAckAfter !== 1'b0 || obsWeOutside) begin
      failCount++;
      $display("FAIL store_ack: ackCycle=%0d lsAck=%b ifAck=%b ackAfter=%b weOutside=%b, expected 3/1/0/0/0",
               obsAck, obsAckLs, obsAckIf, obsAckAfter, obsWeOutside);
    end
    assertCount++;
    if (bus2.ls_rdata !== expLsRdata) begin
      failCount++;
      $display("FAIL store_rdata_kept: lsRdata=%h, expected %h", bus2.ls_rdata, expLsRdata);
    end
  endtask

  task automatic test_back_to_back();
    bit isLs;
    logic [15:0] val;
    doReset();
    for (int t = 0; t < 4; t++) begin
      val = 16'($urandom);
      modelGrant(1'b1, 1'b1, isLs);
      runTxn(1'b1, 8'h30, 1'b1, 1'b0, 8'h50, 16'h0000, val, 1'b1, 1'b0);
      if (isLs) expLsRdata = val; else expIfRdata = val;
      assertCount++;
      if (obsAckLs !== isLs || obsAckIf !== !isLs || obsOverlap || obsAck !== 3) begin
        failCount++;
        $display("FAIL b2b_grant[%0d]: ifAck=%b lsAck=%b overlap=%b ackCycle=%0d, expected lsWins=%b at cycle 3",
                 t, obsAckIf, obsAckLs, obsOverlap, obsAck, isLs);
      end
      assertCount++;
      if (obsBusyAfter !== 1'b0 || obsBusyLow || obsAddr !== (isLs ? 8'h50 : 8'h30)) begin
        failCount++;
        $display("FAIL b2b_busy[%0d]: busyAfter=%b busyLowInTxn=%b addr=%h, expected 0/0/%h",
                 t, obsBusyAfter, obsBusyLow, obsAddr, isLs ? 8'h50 : 8'h30);
      end
    end
    bus2.if_req = 1'b0;
    bus2.ls_req = 1'b0;
    assertCount++;
    if (bus2.if_rdata !== expIfRdata || bus2.ls_rdata !== expLsRdata) begin
      failCount++;
      $display("FAIL b2b_rdata: ifRdata=%h lsRdata=%h, expected %h/%h",
               bus2.if_rdata, bus2.ls_rdata, expIfRdata, expLsRdata);
    end
  endtask

  task automatic test_random();
    bit ifReq, lsReq, lsWe, isLs;
    logic [7:0] ifAddr, lsAddr;
    logic [15:0] wdata, val;
    for (int t = 0; t < 24; t++) begin
      ifReq = 1'($urandom); lsReq = 1'($urandom); lsWe = 1'($urandom);
      ifAddr = 8'($urandom); lsAddr = 8'($urandom);
      wdata = 16'($urandom); val = 16'($urandom);
      if (!ifReq && !lsReq) begin
        @(posedge clk);
        @(negedge clk);
        assertCount++;
        if (bus2.busy !== 1'b0 || bus2.mem_en !== 1'b0) begin
          failCount++;
          $display("FAIL rand_idle[%0d]: busy=%b memEn=%b, expected 0/0", t, bus2.busy, bus2.mem_en);
        end
        continue;
      end
      modelGrant(ifReq, lsReq, isLs);
      runTxn(ifReq, ifAddr, lsReq, lsWe, lsAddr, wdata, val, 1'b0, 1'b0);
      if (!(isLs && lsWe)) begin
        if (isLs) expLsRdata = val; else expIfRdata = val;
      end
      assertCount++;
      if (obsAckLs !== isLs || obsAckIf !== !isLs || obsAck !== 3 || obsEn !== 2 || obsAckAfter || obsEnAfter) begin
        failCount++;
        $display("FAIL rand_txn[%0d]: lsAck=%b ifAck=%b ackCycle=%0d en=%0d ackAfter=%b enAfter=%b, expected lsWins=%b 3 2 0 0",
                 t, obsAckLs, obsAckIf, obsAck, obsEn, obsAckAfter, obsEnAfter, isLs);
      end
      assertCount++;
      if (obsAddr !== (isLs ? lsAddr : ifAddr) || obsWe !== (isLs & lsWe) ||
          (isLs && lsWe && obsWdata !== wdata)) begin
        failCount++;
        $display("FAIL rand_mem[%0d]: addr=%h we=%b wdata=%h, expected %h/%b/%h",
                 t, obsAddr, obsWe, obsWdata, isLs ? lsAddr : ifAddr, isLs & lsWe, wdata);
      end
      assertCount++;
      if (bus2.if_rdata !== expIfRdata || bus2.ls_rdata !== expLsRdata) begin
        failCount++;
        $display("FAIL rand_rdata[%0d]: ifRdata=%h lsRdata=%h, expected %h/%h",
                 t, bus2.if_rdata, bus2.ls_rdata, expIfRdata, expLsRdata);
      end
    end
  endtask

  task automatic test_addr_change();
    bit isLs;
    modelGrant(1'b0, 1'b1, isLs);
    runTxn(1'b0, 8'h00, 1'b1, 1'b1, 8'h6C, 16'hBEEF, 16'h0000, 1'b0, 1'b1);
    assertCount++;
    if (obsAddr !== 8'h6C || obsWdata !== 16'hBEEF || obsWe !== 1'b1 || obsUnstable || obsEn !== 2) begin
      failCount++;
      $display("FAIL addr_change: addr=%h wdata=%h we=%b unstable=%b en=%0d, expected 6C/BEEF/1/0/2",
               obsAddr, obsWdata, obsWe, obsUnstable, obsEn);
    end
    bus2.ls_we = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lateAcks;
    bit isLs;
    @(negedge clk);
    bus2.ls_req = 1'b1; bus2.ls_we = 1'b0; bus2.ls_addr = 8'h77; bus2.mem_rdata = 16'hC3C3;
    @(posedge clk);
    #1;
    bus2.ls_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    assertCount++;
    if (bus2.mem_en !== 1'b1) begin
      failCount++;
      $display("FAIL abort_pre: memEn=%b in 2nd access cycle, expected 1", bus2.mem_en);
    end
    rst = 1'b1;
    lastGrantLs = 1'b1; expIfRdata = '0; expLsRdata = '0;
    #1;
    assertCount++;
    if ({bus2.busy, bus2.if_ack, bus2.ls_ack, bus2.mem_en, bus2.mem_we} !== 5'b0 ||
        {bus2.mem_addr, bus2.mem_wdata, bus2.if_rdata, bus2.ls_rdata} !== 56'd0) begin
      failCount++;
      $display("FAIL abort_outputs: busy=%b acks=%b%b en=%b we=%b addr=%h wdata=%h ifR=%h lsR=%h, expected all 0",
               bus2.busy, bus2.if_ack, bus2.ls_ack, bus2.mem_en, bus2.mem_we,
               bus2.mem_addr, bus2.mem_wdata, bus2.if_rdata, bus2.ls_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    lateAcks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus2.ls_ack || bus2.if_ack || bus2.busy) lateAcks++;
    end
    assertCount++;
    if (lateAcks !== 0 || bus2.ls_rdata !== 16'h0000) begin
      failCount++;
      $display("FAIL abort_no_ack: activeCycles=%0d lsRdata=%h, expected 0/0000", lateAcks, bus2.ls_rdata);
    end
    modelGrant(1'b1, 1'b0, isLs);
    runTxn(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h1F2E, 1'b0, 1'b0);
    expIfRdata = 16'h1F2E;
    assertCount++;
    if (obsAckIf !== 1'b1 || obsAck !== 3 || obsAddr !== 8'h33 || bus2.if_rdata !== expIfRdata) begin
      failCount++;
      $display("FAIL abort_recover: ifAck=%b ackCycle=%0d addr=%h ifRdata=%h, expected 1/3/33/%h",
               obsAckIf, obsAck, obsAddr, bus2.if_rdata, expIfRdata);
    end
  endtask

  task automatic test_wait_extremes();
    int w, enCnt, ackAt;
    bit en, ack;
    logic [15:0] val, rd;
    for (int s = 0; s < 2; s++) begin
      w = (s == 0) ? 1 : 15;
      val = 16'($urandom);
      enCnt = 0; ackAt = 0;
      @(negedge clk);
      if (s == 0) begin bus1.if_req = 1'b1; bus1.if_addr = 8'h3A; bus1.mem_rdata = val; end
      else        begin bus15.if_req = 1'b1; bus15.if_addr = 8'h3A; bus15.mem_rdata = val; end
      @(posedge clk);
      #1;
      bus1.if_req = 1'b0;
      bus15.if_req = 1'b0;
      for (int k = 1; k <= 40 && ackAt == 0; k++) begin
        @(negedge clk);
        en  = (s == 0) ? bus1.mem_en : bus15.mem_en;
        ack = (s == 0) ? bus1.if_ack : bus15.if_ack;
        if (en) enCnt++;
        if (ack) ackAt = k;
      end
      rd = (s == 0) ? bus1.if_rdata : bus15.if_rdata;
      assertCount++;
      if (enCnt !== w || ackAt !== w + 1) begin
        failCount++;
        $display("FAIL wait_%0d_timing: accessCycles=%0d ackCycle=%0d, expected %0d/%0d",
                 w, enCnt, ackAt, w, w + 1);
      end
      assertCount++;
      if (rd !== val) begin
        failCount++;
        $display("FAIL wait_%0d_rdata: ifRdata=%h, expected %h", w, rd, val);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst = 1'b1;
    bus2.if_req = 0; bus2.if_addr = 0; bus2.ls_req = 0; bus2.ls_we = 0;
    bus2.ls_addr = 0; bus2.ls_wdata = 0; bus2.mem_rdata = 0;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.ls_req = 0; bus1.ls_we = 0;
    bus1.ls_addr = 0; bus1.ls_wdata = 0; bus1.mem_rdata = 0;
    bus15.if_req = 0; bus15.if_addr = 0; bus15.ls_req = 0; bus15.ls_we = 0;
    bus15.ls_addr = 0; bus15.ls_wdata = 0; bus15.mem_rdata = 0;

    test_reset();
    $display("[TB] reset checks done");
    test_if_read();
    test_store();
    test_back_to_back();
    test_random();
    test_addr_change();
    test_reset_abort();
    test_wait_extremes();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
